// File: rtl/kw_pkg.sv
// Shared definitions for the keypad word controller: FSM states, key kinds
// and word geometry.
package kw_pkg;

    localparam int unsigned CHAR_W  = 4;
    localparam int unsigned MAX_LEN = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_COMMIT   = 2'd3
    } kw_state_t;

    typedef enum logic {
        KIND_DIGIT = 1'b0,
        KIND_STAR  = 1'b1
    } kw_kind_t;

endpackage

// File: rtl/key_debounce.sv
// Stability counter: pulses 'stable' on the DEB_CYCLES-th consecutive cycle
// in which the sampled inputs still match the latched key.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic match,
    output logic stable
);

    logic [3:0] cnt;

    assign stable = sample && match && (cnt == 4'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!sample || !match || stable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/keypad_word_ctrl.sv
// Debounced keypad entry: collects up to MAX_LEN digit characters and offers
// the word on a valid/ready handshake when the star key is pressed.
module keypad_word_ctrl
    import kw_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MAX_LEN    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [3:0]  key_code,
    input  logic        star_pressed,
    input  logic        word_ready,
    output logic        word_valid,
    output logic [27:0] word_data,
    output logic [2:0]  word_len,
    output logic        char_pulse,
    output logic        overflow
);

    kw_state_t  state;
    kw_kind_t   kind;
    logic [3:0] code;
    logic       match;
    logic       stable;
    logic       full;

    // A digit candidate is lost if star joins in, since star has priority.
    assign match = (kind == KIND_STAR) ? star_pressed
                 : (key_pressed && !star_pressed && (key_code == code));
    assign full       = (word_len == 3'(MAX_LEN));
    assign word_valid = (state == ST_COMMIT);

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .sample(state == ST_DEBOUNCE),
        .match (match),
        .stable(stable)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            kind       <= KIND_DIGIT;
            code       <= '0;
            word_data  <= '0;
            word_len   <= '0;
            char_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            char_pulse <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (star_pressed) begin
                        state <= ST_DEBOUNCE;
                        kind  <= KIND_STAR;
                    end else if (key_pressed) begin
                        state <= ST_DEBOUNCE;
                        kind  <= KIND_DIGIT;
                        code  <= key_code;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!match) begin
                        state <= ST_IDLE;
                    end else if (stable) begin
                        if (kind == KIND_STAR) begin
                            state <= (word_len != '0) ? ST_COMMIT : ST_HELD;
                        end else begin
                            state <= ST_HELD;
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                word_data[{word_len, 2'b00} +: CHAR_W] <= code;
                                word_len   <= word_len + 3'd1;
                                char_pulse <= 1'b1;
                            end
                        end
                    end
                end
                ST_HELD: begin
                    if (!key_pressed && !star_pressed) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    if (word_ready) begin
                        state     <= ST_HELD;
                        word_len  <= '0;
                        word_data <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_word_ctrl.sv
// Randomised and directed bench for keypad_word_ctrl against a queue-based
// model of the typed word.
module tb_keypad_word_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_pressed;
    logic [3:0]  key_code;
    logic        star_pressed;
    logic        word_ready;
    logic        word_valid;
    logic [27:0] word_data;
    logic [2:0]  word_len;
    logic        char_pulse;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int unsigned model_q[$];

    keypad_word_ctrl #(
        .DEB_CYCLES(DEB),
        .MAX_LEN   (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .star_pressed(star_pressed),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_len    (word_len),
        .char_pulse  (char_pulse),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] model_data();
        logic [27:0] d = '0;
        foreach (model_q[i]) d[i*4 +: 4] = model_q[i][3:0];
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a digit for h sampled edges, then release for gap edges.
    task automatic press_digit(input logic [3:0] c, input int h, input int gap);
        bit acc, full, exp_cp, exp_ov;
        acc  = (h >= DEB + 1);
        full = (model_q.size() == 7);
        key_pressed = 1'b1;
        key_code    = c;
        word_ready  = 1'($urandom_range(0, 1));
        for (int i = 1; i <= h; i++) begin
            tick();
            exp_cp = acc && !full && (i == DEB + 1);
            exp_ov = acc && full && (i == DEB + 1);
            checks++;
            if (char_pulse !== exp_cp) begin
                errors++;
                $display("FAIL digit_char_pulse cyc=%0d got %b want %b", i, char_pulse, exp_cp);
            end
            checks++;
            if (overflow !== exp_ov) begin
                errors++;
                $display("FAIL digit_overflow cyc=%0d got %b want %b", i, overflow, exp_ov);
            end
            checks++;
            if (word_valid !== 1'b0) begin
                errors++;
                $display("FAIL digit_word_valid cyc=%0d got %b want 0", i, word_valid);
            end
        end
        key_pressed = 1'b0;
        word_ready  = 1'b0;
        key_code    = 4'($urandom);
        if (acc && !full) model_q.push_back(32'(c));
        for (int i = 0; i < gap; i++) begin
            tick();
            checks++;
            if (char_pulse !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL digit_release_strobe got cp=%b ov=%b want 0/0", char_pulse, overflow);
            end
        end
        checks++;
        if (word_len !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL digit_word_len got %0d want %0d", word_len, model_q.size());
        end
        checks++;
        if (word_data !== model_data()) begin
            errors++;
            $display("FAIL digit_word_data got %h want %h", word_data, model_data());
        end
    endtask

    // Hold star (optionally with a digit) for h edges; if a word is committed,
    // keep ready low for ready_delay cycles before the handshake.
    task automatic press_star(input int h, input int gap, input int ready_delay, input bit with_digit);
        int n;
        bit commit, exp_v;
        n = model_q.size();
        commit = (h >= DEB + 1) && (n > 0);
        star_pressed = 1'b1;
        word_ready   = 1'b0;
        if (with_digit) begin
            key_pressed = 1'b1;
            key_code    = 4'($urandom);
        end
        for (int i = 1; i <= h; i++) begin
            tick();
            exp_v = commit && (i >= DEB + 1);
            checks++;
            if (word_valid !== exp_v) begin
                errors++;
                $display("FAIL star_word_valid cyc=%0d got %b want %b", i, word_valid, exp_v);
            end
            checks++;
            if (char_pulse !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL star_strobe cyc=%0d got cp=%b ov=%b want 0/0", i, char_pulse, overflow);
            end
        end
        star_pressed = 1'b0;
        key_pressed  = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            checks++;
            if (word_valid !== commit) begin
                errors++;
                $display("FAIL star_release_valid got %b want %b", word_valid, commit);
            end
        end
        checks++;
        if (word_len !== 3'(n) || word_data !== model_data()) begin
            errors++;
            $display("FAIL star_word got len=%0d data=%h want len=%0d data=%h",
                     word_len, word_data, n, model_data());
        end
        if (commit) begin
            for (int i = 0; i < ready_delay; i++) begin
                tick();
                checks++;
                if (word_valid !== 1'b1 || word_len !== 3'(n) || word_data !== model_data()) begin
                    errors++;
                    $display("FAIL commit_hold got v=%b len=%0d data=%h want v=1 len=%0d data=%h",
                             word_valid, word_len, word_data, n, model_data());
                end
            end
            word_ready = 1'b1;
            tick();
            word_ready = 1'b0;
            model_q.delete();
            checks++;
            if (word_valid !== 1'b0 || word_len !== 3'd0 || word_data !== 28'd0) begin
                errors++;
                $display("FAIL handshake_clear got v=%b len=%0d data=%h want 0/0/0",
                         word_valid, word_len, word_data);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_pressed = 1'b0;
        key_code = 4'd0;
        star_pressed = 1'b0;
        word_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (word_valid !== 1'b0 || word_len !== 3'd0 || word_data !== 28'd0 ||
            char_pulse !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b len=%0d data=%h cp=%b ov=%b want all 0",
                     word_valid, word_len, word_data, char_pulse, overflow);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_debounce();
        press_digit(4'd3, 10, 2);
        press_digit(4'd5, 2, 2);
        checks++;
        if (word_len !== 3'd1 || word_data !== 28'h3) begin
            errors++;
            $display("FAIL debounce_word got len=%0d data=%h want 1/0000003", word_len, word_data);
        end
        press_star(DEB + 2, 1, 0, 1'b0);
    endtask

    task automatic test_commit_hold();
        press_digit(4'd1, DEB + 2, 1);
        press_digit(4'd2, DEB + 2, 1);
        press_digit(4'd3, DEB + 2, 1);
        checks++;
        if (word_data !== 28'h321) begin
            errors++;
            $display("FAIL commit_data got %h want 0000321", word_data);
        end
        press_star(DEB + 2, 1, 20, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) press_digit(4'(i + 8), DEB + 2, 1);
        checks++;
        if (word_len !== 3'd7 || word_data !== 28'hEDCBA98) begin
            errors++;
            $display("FAIL overflow_word got len=%0d data=%h want 7/edcba98", word_len, word_data);
        end
        press_star(DEB + 3, 2, 3, 1'b0);
    endtask

    task automatic test_empty_star();
        press_star(DEB + 5, 1, 0, 1'b0);
        press_digit(4'd6, DEB + 1, 1);
        press_star(DEB + 1, 1, 1, 1'b0);
    endtask

    task automatic test_simultaneous();
        press_digit(4'd4, DEB + 2, 1);
        press_digit(4'd7, DEB + 2, 1);
        press_star(DEB + 4, 1, 2, 1'b1);
    endtask

    task automatic test_reset_commit();
        bit exp_cp;
        for (int i = 0; i < 4; i++) press_digit(4'(i + 2), DEB + 2, 1);
        star_pressed = 1'b1;
        repeat (DEB + 2) tick();
        checks++;
        if (word_valid !== 1'b1 || word_len !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset_commit got v=%b len=%0d want 1/4", word_valid, word_len);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (word_valid !== 1'b0 || word_len !== 3'd0 || word_data !== 28'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b len=%0d data=%h want 0/0/0", word_valid, word_len, word_data);
        end
        star_pressed = 1'b0;
        model_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        // Reset mid-debounce with the key kept held: counts as a fresh press.
        key_pressed = 1'b1;
        key_code = 4'd9;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= DEB + 3; i++) begin
            tick();
            exp_cp = (i == DEB + 1);
            checks++;
            if (char_pulse !== exp_cp) begin
                errors++;
                $display("FAIL held_after_reset cyc=%0d got %b want %b", i, char_pulse, exp_cp);
            end
        end
        key_pressed = 1'b0;
        model_q.push_back(9);
        tick();
        checks++;
        if (word_len !== 3'd1 || word_data !== 28'h9) begin
            errors++;
            $display("FAIL held_after_reset_word got len=%0d data=%h want 1/0000009", word_len, word_data);
        end
        press_star(DEB + 1, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                press_digit(4'($urandom), int'($urandom_range(1, DEB + 4)), int'($urandom_range(1, 3)));
            end else begin
                press_star(int'($urandom_range(1, DEB + 4)), int'($urandom_range(1, 2)),
                           int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            end
        end
        press_star(DEB + 1, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_commit_hold();
        test_overflow();
        test_empty_star();
        test_simultaneous();
        test_reset_commit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_word_ctrl.md
KEYPAD_WORD_CTRL -- requirements
Module: keypad_word_ctrl

Parameters
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4: the number of consecutive stable cycles needed to accept a key (legal range 1..15).
REQ-002 The block SHALL have parameter MAX_LEN, default 7: the maximum number of characters in a word (fixed at 7 by the 3-bit length).

Interface
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 key_pressed  in  1  level, high while any digit key is held; synchronous to clk.
REQ-006 key_code  in  4  code of the held digit key; valid while key_pressed=1.
REQ-007 star_pressed  in  1  level, high while the star (commit) key is held.
REQ-008 word_ready  in  1  consumer accepts the word when word_valid=1.
REQ-009 word_valid  out  1  a committed word is being offered.
REQ-010 word_data  out  28  characters packed 7x4; char i is at [4i+3:4i]; unused slots are 0.
REQ-011 word_len  out  3  current or committed length, 0..7.
REQ-012 char_pulse  out  1  one-cycle strobe for each accepted character.
REQ-013 overflow  out  1  one-cycle strobe when a digit is dropped because the word is full.

Function
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, HELD and COMMIT.
REQ-015 IDLE: if star_pressed=1, the FSM goes to DEBOUNCE with kind=STAR; else if key_pressed=1, it goes to DEBOUNCE with kind=DIGIT and key_code latched. If both are high in the same cycle, star wins.
REQ-016 DEBOUNCE: the stability counter increments each cycle the inputs match the latched kind/code. On any mismatch or release, the FSM returns to IDLE with no side effects.
REQ-017 When the counter reaches DEB_CYCLES with kind=DIGIT and word_len<7, the latched code SHALL be written at slot word_len, word_len SHALL increment, char_pulse=1 for exactly that cycle, and the FSM goes to HELD.
REQ-018 When the counter reaches DEB_CYCLES with kind=DIGIT and word_len=7, the buffer SHALL be unchanged, overflow=1 for one cycle, and the FSM goes to HELD (no wrap-around).
REQ-019 When the counter reaches DEB_CYCLES with kind=STAR and word_len>0, the FSM goes to COMMIT. With word_len=0, it goes to HELD and nothing is emitted.
REQ-020 HELD: the FSM stays until key_pressed=0 and star_pressed=0 in the same cycle, then goes to IDLE. A held key yields exactly one character.
REQ-021 COMMIT: word_valid=1, and word_data/word_len SHALL stay stable until the handshake. All key inputs are ignored.
REQ-022 Handshake: in the cycle where word_valid=1 and word_ready=1, the transfer occurs. On the next edge, word_len=0, word_data=0, word_valid=0, and the FSM goes to HELD.
REQ-023 word_valid SHALL NOT drop without a handshake. word_ready while word_valid=0 SHALL have no effect.
REQ-024 Latency: char_pulse asserts DEB_CYCLES+1 cycles after key_pressed rises; word_valid asserts DEB_CYCLES+1 cycles after star_pressed rises.

Reset
REQ-025 While reset=0, the FSM SHALL be IDLE and word_len=0, word_data=0, word_valid=0, char_pulse=0, overflow=0, stability counter=0.
REQ-026 Reset asserted mid-DEBOUNCE or mid-COMMIT SHALL discard the pending key or word; no strobe or handshake completes.
REQ-027 After reset releases, a key already held SHALL be treated as a new press (IDLE -> DEBOUNCE).

Structure
REQ-028 A shared package kw_pkg SHALL hold the FSM state enum, the KIND_DIGIT/KIND_STAR encoding, CHAR_W=4 and MAX_LEN=7.
REQ-029 Debounce counting SHALL be a sub-module key_debounce (inputs: sample, match, DEB_CYCLES; output: stable pulse), instantiated once.

Verification
REQ-030 DEB_CYCLES=4; press 3 for 10 cycles, release; press 5 for 2 cycles, release -> one char_pulse, word_len=1, word_data[3:0]=3, slot 1 stays 0.
REQ-031 Enter 1,2,3, then star with word_ready=0 for 20 cycles, then word_ready=1 -> word_valid held 20+ cycles with word_len=3 and word_data=0x321; after the handshake, word_len=0.
REQ-032 Enter 8 digits -> seven char_pulses; the 8th gives overflow=1 for one cycle; word_len=7, data unchanged.
REQ-033 Star with empty word -> no word_valid; the FSM returns to IDLE after release.
REQ-034 key_pressed and star_pressed rise together with word_len=2 -> commit of length 2; no char added.
REQ-035 reset=0 during COMMIT with word_len=4 -> word_valid=0 and word_len=0 immediately (asynchronously), and no transfer is counted.
